// File: rtl/turn_controller.sv
// Turn sequencer for the memory-race game: owns player order, per-turn
// card mask and reveal timing, and drives the data path's command strobes.
module turn_controller #(
    parameter int REVEAL_CYCLES = 50_000_000,
    parameter int CHECK_LAT     = 1,
    parameter int NUM_CARDS     = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] N,
    input  logic       pick_valid,
    input  logic [3:0] pick_idx,
    input  logic       go,
    input  logic       W,
    output logic       check_req,
    output logic [3:0] card_idx,
    output logic       reveal,
    output logic       move_en,
    output logic       flip_back,
    output logic       statecombo_next_turn,
    output logic [1:0] T,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int TW = $clog2(REVEAL_CYCLES + 1);
    localparam int LW = (CHECK_LAT < 1) ? 1 : $clog2(CHECK_LAT + 1);
    localparam logic [TW-1:0] RMAX = TW'(REVEAL_CYCLES - 1);
    localparam logic [LW-1:0] LEND = LW'(CHECK_LAT);
    localparam logic [4:0] NC = 5'(NUM_CARDS);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_PICK, S_CHECK, S_MOVE,
        S_WIN_CHECK, S_REVEAL, S_NEXT, S_GAME_OVER
    } state_t;

    state_t                 r_state, w_state;
    logic [NUM_CARDS-1:0]   r_mask, w_mask;
    logic [TW-1:0]          r_timer, w_timer;
    logic [LW-1:0]          r_lat, w_lat;
    logic [1:0]             r_nl, w_nl;
    logic [1:0]             r_t, w_t;
    logic [3:0]             r_card, w_card;
    logic                   r_check, w_check;
    logic                   r_reveal, w_reveal;
    logic                   r_move, w_move;
    logic                   r_flip, w_flip;
    logic                   r_next, w_next;
    logic                   r_gover, w_gover;
    logic [1:0]             r_winner, w_winner;
    logic [NUM_CARDS-1:0]   w_onehot;
    logic                   w_pick_ok;
    logic                   w_adv;

    // Out-of-range indices shift the bit out entirely; the range test rejects them
    assign w_onehot  = NUM_CARDS'(1) << pick_idx;
    assign w_pick_ok = ({1'b0, pick_idx} < NC) && ((r_mask & w_onehot) == '0);

    always_comb begin
        w_state  = r_state;
        w_mask   = r_mask;
        w_timer  = r_timer;
        w_lat    = r_lat;
        w_nl     = r_nl;
        w_t      = r_t;
        w_card   = r_card;
        w_check  = 1'b0;
        w_reveal = r_reveal;
        w_move   = 1'b0;
        w_flip   = 1'b0;
        w_next   = 1'b0;
        w_gover  = r_gover;
        w_winner = r_winner;
        w_adv    = 1'b0;
        unique case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    w_nl     = (N == 2'd0) ? 2'd1 : N;
                    w_t      = 2'd0;
                    w_mask   = '0;
                    w_gover  = 1'b0;
                    w_winner = 2'd0;
                    w_state  = S_WAIT_PICK;
                end
            end
            S_WAIT_PICK: begin
                if (pick_valid && w_pick_ok) begin
                    w_card   = pick_idx;
                    w_mask   = r_mask | w_onehot;
                    w_reveal = 1'b1;
                    w_check  = 1'b1;
                    w_lat    = '0;
                    w_state  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_lat == LEND) begin
                    if (go) begin
                        w_move  = 1'b1;
                        w_state = S_MOVE;
                    end else begin
                        w_timer = '0;
                        w_state = S_REVEAL;
                    end
                end else begin
                    w_lat = r_lat + 1'b1;
                end
            end
            S_MOVE: w_state = S_WIN_CHECK;
            S_WIN_CHECK: begin
                if (W) begin
                    w_winner = r_t;
                    w_gover  = 1'b1;
                    w_reveal = 1'b0;
                    w_state  = S_GAME_OVER;
                end else if (&r_mask) begin
                    w_adv = 1'b1;
                end else begin
                    w_state = S_WAIT_PICK;
                end
            end
            S_REVEAL: begin
                if (r_timer == RMAX) w_adv = 1'b1;
                else w_timer = r_timer + 1'b1;
            end
            S_NEXT: w_state = S_WAIT_PICK;
            default: w_state = S_IDLE;
        endcase
        if (w_adv) begin
            w_flip   = 1'b1;
            w_next   = 1'b1;
            w_reveal = 1'b0;
            w_mask   = '0;
            w_t      = (r_t == r_nl) ? 2'd0 : r_t + 2'd1;
            w_state  = S_NEXT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_mask   <= '0;
            r_timer  <= '0;
            r_lat    <= '0;
            r_nl     <= 2'd0;
            r_t      <= 2'd0;
            r_card   <= 4'd0;
            r_check  <= 1'b0;
            r_reveal <= 1'b0;
            r_move   <= 1'b0;
            r_flip   <= 1'b0;
            r_next   <= 1'b0;
            r_gover  <= 1'b0;
            r_winner <= 2'd0;
        end else begin
            r_state  <= w_state;
            r_mask   <= w_mask;
            r_timer  <= w_timer;
            r_lat    <= w_lat;
            r_nl     <= w_nl;
            r_t      <= w_t;
            r_card   <= w_card;
            r_check  <= w_check;
            r_reveal <= w_reveal;
            r_move   <= w_move;
            r_flip   <= w_flip;
            r_next   <= w_next;
            r_gover  <= w_gover;
            r_winner <= w_winner;
        end
    end

    assign check_req            = r_check;
    assign card_idx             = r_card;
    assign reveal               = r_reveal;
    assign move_en              = r_move;
    assign flip_back            = r_flip;
    assign statecombo_next_turn = r_next;
    assign T                    = r_t;
    assign game_over            = r_gover;
    assign winner               = r_winner;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with a short reveal window.
module tb_turn_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] N;
    logic       pick_valid;
    logic [3:0] pick_idx;
    logic       go;
    logic       W;
    logic       check_req;
    logic [3:0] card_idx;
    logic       reveal;
    logic       move_en;
    logic       flip_back;
    logic       nt;
    logic [1:0] T;
    logic       game_over;
    logic [1:0] winner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    turn_controller #(
        .REVEAL_CYCLES(4),
        .CHECK_LAT(1),
        .NUM_CARDS(12)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .N(N),
        .pick_valid(pick_valid),
        .pick_idx(pick_idx),
        .go(go),
        .W(W),
        .check_req(check_req),
        .card_idx(card_idx),
        .reveal(reveal),
        .move_en(move_en),
        .flip_back(flip_back),
        .statecombo_next_turn(nt),
        .T(T),
        .game_over(game_over),
        .winner(winner)
    );

    typedef struct {
        logic       start;
        logic [1:0] n;
        logic       pv;
        logic [3:0] idx;
        logic       go;
        logic       w;
        logic       cr;
        logic [3:0] cidx;
        logic       rv;
        logic       mv;
        logic       fb;
        logic       nt;
        logic [1:0] t;
        logic       gov;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[23];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_pick(input logic [3:0] idx);
        pick_valid = 1'b1;
        pick_idx   = idx;
        tick();
        pick_valid = 1'b0;
        chk($sformatf("pick%0d.check_req", idx), 8'(check_req), 8'd1);
        chk($sformatf("pick%0d.card_idx", idx), 8'(card_idx), 8'(idx));
    endtask

    task automatic wait_flip(input string name);
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (flip_back) begin
                seen = 1'b1;
                break;
            end
        end
        chk({name, ".flip_seen"}, 8'(seen), 8'd1);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if ((32'(check_req) + 32'(move_en) + 32'(flip_back)) > 1) begin
                errors++;
                $display("FAIL exclusive_strobes: cr=%0b mv=%0b fb=%0b required at most one",
                         check_req, move_en, flip_back);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // start n pv idx go w | cr cidx rv mv fb nt t gov win
        vecs[0]  = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 2, 1, 5, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 2, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 2, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 2, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 2, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 1, 1, 1, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 1, 0, 0};
        vecs[9]  = '{0, 0, 1, 3, 1, 0, 1, 3, 1, 0, 0, 0, 1, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 1, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0};
        vecs[14] = '{0, 0, 1, 3, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0};
        vecs[15] = '{0, 0, 1, 13, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0};
        vecs[16] = '{0, 0, 1, 7, 1, 1, 1, 7, 1, 0, 0, 0, 1, 0, 0};
        vecs[17] = '{0, 0, 0, 0, 1, 1, 0, 7, 1, 0, 0, 0, 1, 0, 0};
        vecs[18] = '{0, 0, 0, 0, 1, 1, 0, 7, 1, 1, 0, 0, 1, 0, 0};
        vecs[19] = '{0, 0, 0, 0, 0, 1, 0, 7, 1, 0, 0, 0, 1, 0, 0};
        vecs[20] = '{0, 0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 1, 1, 1};
        vecs[21] = '{0, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0, 1, 1, 1};
        vecs[22] = '{1, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        start = 1'b0;
        N = 2'd0;
        pick_valid = 1'b0;
        pick_idx = 4'd0;
        go = 1'b0;
        W = 1'b0;
        #3 rst = 1'b0;
        tick();
        tick();
        chk("rst.check_req", 8'(check_req), 8'd0);
        chk("rst.reveal", 8'(reveal), 8'd0);
        chk("rst.T", 8'(T), 8'd0);
        chk("rst.game_over", 8'(game_over), 8'd0);
        rst = 1'b1;

        for (int i = 0; i < 23; i++) begin
            start      = vecs[i].start;
            N          = vecs[i].n;
            pick_valid = vecs[i].pv;
            pick_idx   = vecs[i].idx;
            go         = vecs[i].go;
            W          = vecs[i].w;
            tick();
            chk($sformatf("v%0d.check_req", i), 8'(check_req), 8'(vecs[i].cr));
            chk($sformatf("v%0d.card_idx", i), 8'(card_idx), 8'(vecs[i].cidx));
            chk($sformatf("v%0d.reveal", i), 8'(reveal), 8'(vecs[i].rv));
            chk($sformatf("v%0d.move_en", i), 8'(move_en), 8'(vecs[i].mv));
            chk($sformatf("v%0d.flip_back", i), 8'(flip_back), 8'(vecs[i].fb));
            chk($sformatf("v%0d.next_turn", i), 8'(nt), 8'(vecs[i].nt));
            chk($sformatf("v%0d.T", i), 8'(T), 8'(vecs[i].t));
            chk($sformatf("v%0d.game_over", i), 8'(game_over), 8'(vecs[i].gov));
            chk($sformatf("v%0d.winner", i), 8'(winner), 8'(vecs[i].win));
        end
        start = 1'b0;
        pick_valid = 1'b0;
        go = 1'b0;
        W = 1'b0;

        // N=0 plays as two players: T goes 0,1,0,1
        chk("n0.T0", 8'(T), 8'd0);
        for (int k = 0; k < 3; k++) begin
            do_pick(4'(k + 1));
            wait_flip($sformatf("n0.turn%0d", k));
            chk($sformatf("n0.turn%0d.T", k), 8'(T), 8'((k + 1) % 2));
            chk($sformatf("n0.turn%0d.nt", k), 8'(nt), 8'd1);
            chk($sformatf("n0.turn%0d.reveal", k), 8'(reveal), 8'd0);
            tick();
        end

        // asynchronous reset in the middle of the reveal window
        do_pick(4'd5);
        tick();
        tick();
        chk("rstmid.reveal_before", 8'(reveal), 8'd1);
        rst = 1'b0;
        #1;
        chk("rstmid.reveal", 8'(reveal), 8'd0);
        chk("rstmid.card_idx", 8'(card_idx), 8'd0);
        chk("rstmid.T", 8'(T), 8'd0);
        chk("rstmid.strobes", 8'({check_req, move_en, flip_back, nt}), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pick_valid = 1'b1;
        pick_idx = 4'd4;
        tick();
        pick_valid = 1'b0;
        chk("idle_pick.check_req", 8'(check_req), 8'd0);
        chk("idle_pick.reveal", 8'(reveal), 8'd0);

        // match chain won by player 0
        start = 1'b1;
        N = 2'd1;
        tick();
        start = 1'b0;
        go = 1'b1;
        W = 1'b0;
        do_pick(4'd3);
        tick();
        tick();
        chk("chain1.move_en", 8'(move_en), 8'd1);
        tick();
        chk("chain1.move_off", 8'(move_en), 8'd0);
        tick();
        chk("chain1.reveal_kept", 8'(reveal), 8'd1);
        chk("chain1.T", 8'(T), 8'd0);
        W = 1'b1;
        do_pick(4'd7);
        tick();
        tick();
        chk("chain2.move_en", 8'(move_en), 8'd1);
        tick();
        tick();
        chk("chain2.game_over", 8'(game_over), 8'd1);
        chk("chain2.winner", 8'(winner), 8'd0);
        chk("chain2.T", 8'(T), 8'd0);
        chk("chain2.reveal", 8'(reveal), 8'd0);
        W = 1'b0;
        pick_valid = 1'b1;
        pick_idx = 4'd2;
        tick();
        pick_valid = 1'b0;
        chk("over_pick.check_req", 8'(check_req), 8'd0);
        chk("over_pick.game_over", 8'(game_over), 8'd1);

        // all twelve cards matched without a win
        start = 1'b1;
        N = 2'd3;
        tick();
        start = 1'b0;
        go = 1'b1;
        W = 1'b0;
        for (int k = 0; k < 12; k++) begin
            do_pick(4'(k));
            tick();
            tick();
            chk($sformatf("all%0d.move_en", k), 8'(move_en), 8'd1);
            tick();
            tick();
            if (k < 11) begin
                chk($sformatf("all%0d.flip", k), 8'(flip_back), 8'd0);
                chk($sformatf("all%0d.reveal", k), 8'(reveal), 8'd1);
            end else begin
                chk("all11.flip", 8'(flip_back), 8'd1);
                chk("all11.nt", 8'(nt), 8'd1);
                chk("all11.reveal", 8'(reveal), 8'd0);
                chk("all11.T", 8'(T), 8'd1);
            end
        end
        tick();
        go = 1'b0;
        do_pick(4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
